// File: rtl/tile_loop_sequencer_if.sv
// Purpose: handshake/bus bundle between a loop-nest controller and tile_loop_sequencer.
// Latency: none; plain wires.
// Backpressure: ready_i from the consumer holds the current index tuple.
// Ports: start_i/abort_i control, bound_{k,n,m}_i inclusive last indices, ready_i accept;
//        valid_o, idx_{k,n,m}_o tuple, first_k_o/last_k_o accumulator markers, busy_o, done_o.
interface tile_loop_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start_i;
  logic             abort_i;
  logic [WIDTH-1:0] bound_k_i;
  logic [WIDTH-1:0] bound_n_i;
  logic [WIDTH-1:0] bound_m_i;
  logic             ready_i;
  logic             valid_o;
  logic [WIDTH-1:0] idx_k_o;
  logic [WIDTH-1:0] idx_n_o;
  logic [WIDTH-1:0] idx_m_o;
  logic             first_k_o;
  logic             last_k_o;
  logic             busy_o;
  logic             done_o;

  // Controller / consumer side.
  modport master (
    output start_i, abort_i, bound_k_i, bound_n_i, bound_m_i, ready_i,
    input  valid_o, idx_k_o, idx_n_o, idx_m_o, first_k_o, last_k_o, busy_o, done_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, abort_i, bound_k_i, bound_n_i, bound_m_i, ready_i,
    output valid_o, idx_k_o, idx_n_o, idx_m_o, first_k_o, last_k_o, busy_o, done_o
  );
endinterface

// File: rtl/tile_loop_sequencer.sv
// Purpose: walks a 3-deep (M outer, N middle, K inner) loop nest, one index tuple per beat.
// Latency: first tuple valid the cycle after start_i is accepted; done_o one cycle after the last beat.
// Backpressure: without ready_i the tuple holds; abort_i drops the run without a done_o pulse.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport of tile_loop_sequencer_if).
module tile_loop_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tile_loop_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bk_q, bk_d, bn_q, bn_d, bm_q, bm_d;
  logic [WIDTH-1:0] k_q, k_d, n_q, n_d, m_q, m_d;
  logic             beat;

  assign beat = (state_q == RUN) && bus.ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bk_q    <= '0;
      bn_q    <= '0;
      bm_q    <= '0;
      k_q     <= '0;
      n_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      bk_q    <= bk_d;
      bn_q    <= bn_d;
      bm_q    <= bm_d;
      k_q     <= k_d;
      n_q     <= n_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bk_d    = bk_q;
    bn_d    = bn_q;
    bm_d    = bm_q;
    k_d     = k_q;
    n_d     = n_q;
    m_d     = m_q;
    unique case (state_q)
      IDLE: begin
        // abort_i is meaningless here, so start_i wins even if both are high.
        if (bus.start_i) begin
          state_d = RUN;
          bk_d    = bus.bound_k_i;
          bn_d    = bus.bound_n_i;
          bm_d    = bus.bound_m_i;
          k_d     = '0;
          n_d     = '0;
          m_d     = '0;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          // A coincident beat is still consumed downstream, but the walk stops here.
          state_d = IDLE;
          k_d     = '0;
          n_d     = '0;
          m_d     = '0;
        end else if (beat) begin
          // Wrap on equality with the bound so a bound of all-ones never overflows.
          if (k_q == bk_q) begin
            k_d = '0;
            if (n_q == bn_q) begin
              n_d = '0;
              if (m_q == bm_q) begin
                m_d     = '0;
                state_d = DONE;
              end else begin
                m_d = m_q + WIDTH'(1);
              end
            end else begin
              n_d = n_q + WIDTH'(1);
            end
          end else begin
            k_d = k_q + WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign bus.valid_o   = (state_q == RUN);
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = (state_q == DONE);
  assign bus.idx_k_o   = k_q;
  assign bus.idx_n_o   = n_q;
  assign bus.idx_m_o   = m_q;
  assign bus.first_k_o = (state_q == RUN) && (k_q == '0);
  assign bus.last_k_o  = (state_q == RUN) && (k_q == bk_q);

endmodule

// File: tb/tb_tile_loop_sequencer.sv
// Purpose: randomized self-checking bench for tile_loop_sequencer against an arithmetic loop-nest model.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: ready_i randomized per cycle in selected runs; abort_i injected at chosen beats.
module tb_tile_loop_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  tile_loop_sequencer_if #(.WIDTH(8)) b ();
  tile_loop_sequencer_if #(.WIDTH(4)) b4 ();

  tile_loop_sequencer #(.WIDTH(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b)
  );

  tile_loop_sequencer #(.WIDTH(4)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, int'(b.valid_o), 0);
    check_eq({tag, "_busy"},  int'(b.busy_o),  0);
    check_eq({tag, "_done"},  int'(b.done_o),  0);
    check_eq({tag, "_first"}, int'(b.first_k_o), 0);
    check_eq({tag, "_last"},  int'(b.last_k_o),  0);
    check_eq({tag, "_idx"},   int'({b.idx_m_o, b.idx_n_o, b.idx_k_o}), 0);
  endtask

  // Called at a falling edge; returns at a falling edge with the DUT back in IDLE.
  // abort_at < 0 means no abort. noise scribbles bounds/start/abort where they must be ignored.
  task automatic run(input int kb, input int nb, input int mb, input bit rand_rdy,
                     input int abort_at, input bit noise);
    int  total;
    int  beat;
    int  cyc;
    bit  aborted;
    int  ek, en, em;
    total   = (kb + 1) * (nb + 1) * (mb + 1);
    beat    = 0;
    cyc     = 0;
    aborted = 1'b0;
    b.bound_k_i = 8'(kb);
    b.bound_n_i = 8'(nb);
    b.bound_m_i = 8'(mb);
    b.start_i   = 1'b1;
    b.abort_i   = 1'($urandom_range(0, 1));
    b.ready_i   = 1'b0;
    @(negedge clk);
    b.start_i = 1'b0;
    b.abort_i = 1'b0;
    check_eq("start_busy", int'(b.busy_o), 1);
    while (beat < total && !aborted && cyc < 4 * total + 20) begin
      ek = beat % (kb + 1);
      en = (beat / (kb + 1)) % (nb + 1);
      em = beat / ((kb + 1) * (nb + 1));
      check_eq("run_valid", int'(b.valid_o), 1);
      check_eq("run_idx_k", int'(b.idx_k_o), ek);
      check_eq("run_idx_n", int'(b.idx_n_o), en);
      check_eq("run_idx_m", int'(b.idx_m_o), em);
      check_eq("run_first", int'(b.first_k_o), int'(ek == 0));
      check_eq("run_last",  int'(b.last_k_o),  int'(ek == kb));
      check_eq("run_done",  int'(b.done_o), 0);
      if (noise) begin
        b.bound_k_i = 8'($urandom);
        b.bound_n_i = 8'($urandom);
        b.bound_m_i = 8'($urandom);
        b.start_i   = 1'($urandom_range(0, 1));
      end
      b.ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beat == abort_at) begin
        b.ready_i = 1'b1;
        b.abort_i = 1'b1;
        aborted   = 1'b1;
      end
      @(negedge clk);
      b.abort_i = 1'b0;
      if (b.ready_i && !aborted) beat++;
      cyc++;
    end
    b.ready_i = 1'b0;
    b.start_i = 1'b0;
    if (aborted) begin
      check_idle("abort");
    end else begin
      check_eq("beat_count", beat, total);
      check_eq("done_pulse", int'(b.done_o), 1);
      check_eq("done_valid", int'(b.valid_o), 0);
      check_eq("done_busy",  int'(b.busy_o), 1);
      check_eq("done_idx",   int'({b.idx_m_o, b.idx_n_o, b.idx_k_o}), 0);
      if (noise) begin
        b.start_i = 1'($urandom_range(0, 1));
        b.abort_i = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      b.start_i = 1'b0;
      b.abort_i = 1'b0;
      check_idle("after_done");
    end
  endtask

  initial begin
    int k4;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    b.start_i = 1'b0;  b.abort_i = 1'b0;  b.ready_i = 1'b0;
    b.bound_k_i = '0;  b.bound_n_i = '0;  b.bound_m_i = '0;
    b4.start_i = 1'b0; b4.abort_i = 1'b0; b4.ready_i = 1'b0;
    b4.bound_k_i = '0; b4.bound_n_i = '0; b4.bound_m_i = '0;

    // Reset and quiet idle.
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_hold");

    // Directed runs.
    run(2, 1, 1, 1'b0, -1, 1'b0);
    run(0, 0, 0, 1'b0, -1, 1'b0);
    run(3, 0, 0, 1'b1, -1, 1'b1);
    run(2, 1, 1, 1'b0, 4, 1'b0);
    run(2, 1, 1, 1'b0, -1, 1'b0);
    run(255, 0, 0, 1'b0, -1, 1'b0);

    // Randomized runs, some aborted, all back-to-back.
    for (int r = 0; r < 10; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1, 1'b1);
    end

    // Narrow instance: a bound of all-ones must count the whole range.
    b4.bound_k_i = 4'd15;
    b4.start_i   = 1'b1;
    b4.ready_i   = 1'b1;
    @(negedge clk);
    b4.start_i = 1'b0;
    k4 = 0;
    while (k4 < 16) begin
      check_eq("w4_valid", int'(b4.valid_o), 1);
      check_eq("w4_idx_k", int'(b4.idx_k_o), k4);
      check_eq("w4_last",  int'(b4.last_k_o), int'(k4 == 15));
      @(negedge clk);
      k4++;
    end
    check_eq("w4_done",  int'(b4.done_o), 1);
    check_eq("w4_valid_end", int'(b4.valid_o), 0);
    b4.ready_i = 1'b0;
    @(negedge clk);
    check_eq("w4_busy", int'(b4.busy_o), 0);

    // Asynchronous reset in the middle of a run.
    b.bound_k_i = 8'd2; b.bound_n_i = 8'd1; b.bound_m_i = 8'd1;
    b.start_i = 1'b1;
    @(negedge clk);
    b.start_i = 1'b0;
    b.ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", int'(b.busy_o), 1);
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    b.ready_i = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("post_rst");
    run(1, 1, 0, 1'b1, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
